// File: rtl/apb_exe_ctrl.sv
// APB3 slave front-end for the execution unit: operand/opcode registers,
// start pulse, latency window and result capture into a status register.
module apb_exe_ctrl #(
  parameter int BITS    = 4,
  parameter int OP_W    = 3,
  parameter int LATENCY = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_psel,
  input  logic              i_penable,
  input  logic              i_pwrite,
  input  logic [3:0]        i_paddr,
  input  logic [31:0]       i_pwdata,
  output logic [31:0]       o_prdata,
  output logic              o_pready,
  output logic              o_pslverr,
  output logic [BITS-1:0]   o_argA,
  output logic [BITS-1:0]   o_argB,
  output logic [OP_W-1:0]   o_opcode,
  output logic              o_start,
  input  logic [BITS-1:0]   i_result
);

  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_EXEC = 1'b1;

  localparam logic [1:0] IDX_ARG_A  = 2'd0;
  localparam logic [1:0] IDX_ARG_B  = 2'd1;
  localparam logic [1:0] IDX_CTRL   = 2'd2;
  localparam logic [1:0] IDX_STATUS = 2'd3;

  logic            state;
  logic [CW-1:0]   cnt;
  logic [BITS-1:0] arg_a;
  logic [BITS-1:0] arg_b;
  logic [OP_W-1:0] opcode;
  logic [BITS-1:0] result;
  logic            done;
  logic            start_q;

  logic            access;
  logic            busy;
  logic [1:0]      idx;
  logic            wr_en;
  logic            start_acc;
  logic [31:0]     rdata;
  logic            unused_ok;

  assign access = i_psel & i_penable;
  assign busy   = (state == ST_EXEC);
  assign idx    = i_paddr[3:2];

  // A STATUS read during EXEC stalls until the result has been captured.
  assign o_pready  = ~(access & ~i_pwrite & (idx == IDX_STATUS) & busy);
  assign o_pslverr = access & i_pwrite & (busy | (idx == IDX_STATUS));
  assign wr_en     = access & i_pwrite & ~o_pslverr;
  assign start_acc = wr_en & (idx == IDX_CTRL) & i_pwdata[31];

  assign unused_ok = ^{i_paddr[1:0], i_pwdata};

  always_comb begin
    rdata = '0;
    case (idx)
      IDX_ARG_A: rdata[BITS-1:0] = arg_a;
      IDX_ARG_B: rdata[BITS-1:0] = arg_b;
      IDX_CTRL:  rdata[OP_W-1:0] = opcode;
      default: begin
        rdata[BITS-1:0] = result;
        rdata[30]       = busy;
        rdata[31]       = done;
      end
    endcase
  end

  assign o_prdata = (access & ~i_pwrite & o_pready) ? rdata : '0;
  assign o_argA   = arg_a;
  assign o_argB   = arg_b;
  assign o_opcode = opcode;
  assign o_start  = start_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      arg_a   <= '0;
      arg_b   <= '0;
      opcode  <= '0;
      result  <= '0;
      done    <= 1'b0;
      start_q <= 1'b0;
    end else begin
      start_q <= start_acc;
      if (wr_en && idx == IDX_ARG_A) arg_a  <= i_pwdata[BITS-1:0];
      if (wr_en && idx == IDX_ARG_B) arg_b  <= i_pwdata[BITS-1:0];
      if (wr_en && idx == IDX_CTRL)  opcode <= i_pwdata[OP_W-1:0];
      case (state)
        ST_IDLE: begin
          if (start_acc) begin
            state <= ST_EXEC;
            cnt   <= CNT_LOAD;
            done  <= 1'b0;
          end
        end
        default: begin
          if (cnt == CNT_ONE) begin
            result <= i_result;
            done   <= 1'b1;
            state  <= ST_IDLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_exe_ctrl.sv
// Directed bench for apb_exe_ctrl against a cycle-count based register model.
module tb_apb_exe_ctrl;

  localparam int BITS = 4;
  localparam int OP_W = 3;
  localparam int LAT  = 2;

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic            i_psel = 1'b0;
  logic            i_penable = 1'b0;
  logic            i_pwrite = 1'b0;
  logic [3:0]      i_paddr = '0;
  logic [31:0]     i_pwdata = '0;
  logic [31:0]     o_prdata;
  logic            o_pready;
  logic            o_pslverr;
  logic [BITS-1:0] o_argA;
  logic [BITS-1:0] o_argB;
  logic [OP_W-1:0] o_opcode;
  logic            o_start;
  logic [BITS-1:0] i_result;

  apb_exe_ctrl #(.BITS(BITS), .OP_W(OP_W), .LATENCY(LAT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_psel(i_psel), .i_penable(i_penable),
    .i_pwrite(i_pwrite), .i_paddr(i_paddr), .i_pwdata(i_pwdata),
    .o_prdata(o_prdata), .o_pready(o_pready), .o_pslverr(o_pslverr),
    .o_argA(o_argA), .o_argB(o_argB), .o_opcode(o_opcode), .o_start(o_start),
    .i_result(i_result)
  );

  always #5 i_clk = ~i_clk;

  // Downstream unit: signed A >= B.
  assign i_result = ($signed(o_argA) >= $signed(o_argB)) ? BITS'(1) : '0;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Model: registers plus the edge number at which the last start was accepted.
  logic [31:0] m_a = '0, m_b = '0, m_op = '0, res_old = '0, res_new = '0;
  bit          started = 1'b0;
  int          t_start = 0;

  function automatic bit m_busy();
    return started && (cyc < t_start + LAT);
  endfunction

  function automatic bit m_done();
    return started && (cyc >= t_start + LAT);
  endfunction

  function automatic logic [31:0] m_res();
    return m_done() ? res_new : res_old;
  endfunction

  function automatic int to_signed(input logic [31:0] v);
    return (v >= (1 << (BITS - 1))) ? int'(v) - (1 << BITS) : int'(v);
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] idx);
    logic [31:0] s;
    case (idx)
      2'd0: return m_a;
      2'd1: return m_b;
      2'd2: return m_op;
      default: begin
        s = m_res();
        if (m_done()) s = s + 32'h8000_0000;
        if (m_busy()) s = s + 32'h4000_0000;
        return s;
      end
    endcase
  endfunction

  task automatic model_reset();
    m_a = '0; m_b = '0; m_op = '0; res_old = '0; res_new = '0; started = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Continuous outputs every cycle; bus outputs whenever no transfer is on the bus.
  always @(negedge i_clk) begin
    check("argA", 32'(o_argA), m_a);
    check("argB", 32'(o_argB), m_b);
    check("opcode", 32'(o_opcode), m_op);
    check("start", 32'(o_start), 32'(started && cyc == t_start));
    if (!i_psel) begin
      check("idle_pready", 32'(o_pready), 32'd1);
      check("idle_pslverr", 32'(o_pslverr), 32'd0);
      check("idle_prdata", o_prdata, 32'd0);
    end
  end

  // Starts a transfer immediately (setup phase now) and returns #1 after its completing edge.
  task automatic apb(input bit wr, input logic [1:0] idx, input logic [31:0] wd,
                     output logic [31:0] rd, output bit err, output int waits);
    bit got;
    bit exp_err;
    i_psel = 1'b1; i_penable = 1'b0; i_pwrite = wr; i_paddr = {idx, 2'b00}; i_pwdata = wd;
    @(posedge i_clk); #1 i_penable = 1'b1;
    waits = 0; got = 1'b0; rd = '0; err = 1'b0; exp_err = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      check("pready", 32'(o_pready), 32'(!(!wr && idx == 2'd3 && m_busy())));
      if (o_pready) begin
        got = 1'b1;
        break;
      end
      waits++;
      @(posedge i_clk); #1;
    end
    if (!got) begin
      checks++; fails++;
      $display("FAIL pready_timeout: got 0 expected 1 within 20 cycles");
    end else begin
      exp_err = wr && (idx == 2'd3 || m_busy());
      check("pslverr", 32'(o_pslverr), 32'(exp_err));
      check("prdata", o_prdata, wr ? 32'd0 : m_read(idx));
      rd = o_prdata; err = o_pslverr;
    end
    @(posedge i_clk); #1;
    i_psel = 1'b0; i_penable = 1'b0; i_pwrite = 1'b0;
    if (got && wr && !exp_err) begin
      case (idx)
        2'd0: m_a = wd & ((32'd1 << BITS) - 1);
        2'd1: m_b = wd & ((32'd1 << BITS) - 1);
        2'd2: begin
          m_op = wd & ((32'd1 << OP_W) - 1);
          if (wd[31]) begin
            res_old = m_res();
            res_new = (to_signed(m_a) >= to_signed(m_b)) ? 32'd1 : 32'd0;
            started = 1'b1;
            t_start = cyc;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic wr(input logic [1:0] idx, input logic [31:0] wd);
    logic [31:0] rd; bit err; int waits;
    apb(1'b1, idx, wd, rd, err, waits);
  endtask

  logic [31:0] rd;
  bit          err;
  int          waits;

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    // Power-on reset.
    repeat (2) @(negedge i_clk);
    check("rst_start", 32'(o_start), 32'd0);
    check("rst_pready", 32'(o_pready), 32'd1);
    #2 i_rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 4; i++) begin
      apb(1'b0, 2'(i), '0, rd, err, waits);
      check("rst_reg", rd, 32'd0);
    end

    // Basic op: 5 >= 3.
    wr(2'd0, 32'h5);
    wr(2'd1, 32'h3);
    wr(2'd2, 32'h8000_0002);
    check("opcode_lit", 32'(o_opcode), 32'd2);
    idle(1);
    apb(1'b0, 2'd3, '0, rd, err, waits);
    check("basic_status", rd, 32'h8000_0001);
    check("basic_waits", 32'(waits), 32'd0);

    // Immediate STATUS read stalls: -2 >= 1 is false.
    wr(2'd0, 32'hE);
    wr(2'd1, 32'h1);
    wr(2'd2, 32'h8000_0002);
    apb(1'b0, 2'd3, '0, rd, err, waits);
    check("ws_waits", 32'(waits), 32'd1);
    check("ws_status", rd, 32'h8000_0000);

    // Busy errors.
    wr(2'd2, 32'h8000_0001);
    apb(1'b1, 2'd0, 32'h7, rd, err, waits);
    check("busy_wr_err", 32'(err), 32'd1);
    wr(2'd2, 32'h8000_0001);
    apb(1'b1, 2'd3, 32'h1234, rd, err, waits);
    check("status_wr_err", 32'(err), 32'd1);
    apb(1'b0, 2'd0, '0, rd, err, waits);
    check("argA_kept", rd, 32'hE);
    apb(1'b0, 2'd3, '0, rd, err, waits);
    check("status_after_err", rd, 32'h8000_0000);

    // Start accepted in the first cycle back in IDLE.
    wr(2'd0, 32'h2);
    wr(2'd2, 32'h8000_0003);
    idle(1);
    wr(2'd2, 32'h8000_0004);
    apb(1'b0, 2'd3, '0, rd, err, waits);
    check("b2b_status", rd, 32'h8000_0001);

    // Masking and no-start CTRL write.
    wr(2'd1, 32'hFFFF_FFFF);
    apb(1'b0, 2'd1, '0, rd, err, waits);
    check("mask_argB", rd, 32'h0000_000F);
    wr(2'd2, 32'h0000_0005);
    idle(2);
    apb(1'b0, 2'd2, '0, rd, err, waits);
    check("ctrl_nostart", rd, 32'h0000_0005);

    // Mid-cycle reset clears everything.
    #2 i_rst_n = 1'b0;
    model_reset();
    #1;
    check("mrst_start", 32'(o_start), 32'd0);
    check("mrst_pready", 32'(o_pready), 32'd1);
    @(negedge i_clk); #2 i_rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 4; i++) begin
      apb(1'b0, 2'(i), '0, rd, err, waits);
      check("mrst_reg", rd, 32'd0);
    end

    // Reset during EXEC with a stalled STATUS read pending.
    wr(2'd0, 32'h3);
    wr(2'd2, 32'h8000_0001);
    i_psel = 1'b1; i_penable = 1'b0; i_pwrite = 1'b0; i_paddr = 4'hC;
    @(posedge i_clk); #1 i_penable = 1'b1;
    @(negedge i_clk);
    check("exec_stall", 32'(o_pready), 32'd0);
    #2 i_rst_n = 1'b0;
    model_reset();
    #1;
    check("abandon_pready", 32'(o_pready), 32'd1);
    check("abandon_prdata", o_prdata, 32'd0);
    i_psel = 1'b0; i_penable = 1'b0;
    @(negedge i_clk); #2 i_rst_n = 1'b1;
    idle(LAT + 2);
    apb(1'b0, 2'd3, '0, rd, err, waits);
    check("exec_rst_status", rd, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/apb_exe_ctrl.md
# apb_exe_ctrl

APB3 slave front-end for the execution unit: holds operand and opcode registers, drives them into the execution unit, times a start-to-result window, and captures the unit's result into a readable status register. It sits directly upstream of the execution unit and its arithmetic/comparison sub-blocks, and is the only path by which the APB master reaches them.

## Interface
- BITS, 4: operand/result width driven to and captured from the execution unit (1..30).
- OP_W, 3: opcode width (1..8).
- LATENCY, 2: cycles from start to result capture (≥1).

- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_psel, i_penable, i_pwrite  in  1 each  APB3 control.
- i_paddr  in  4  byte address; only [3:2] decoded.
- i_pwdata  in  32  write data.
- o_prdata  out  32  read data.
- o_pready  out  1  APB ready.
- o_pslverr  out  1  APB error.
- o_argA, o_argB  out  BITS  operands to execution unit (from ARG_A/ARG_B registers).
- o_opcode  out  OP_W  operation select (from CTRL).
- o_start  out  1  one-cycle start pulse.
- i_result  in  BITS  execution unit result.

## Operation
- Register map (word index = i_paddr[3:2]):
  - 0 ARG_A: RW, bits [BITS-1:0]; upper bits read 0.
  - 1 ARG_B: RW, same as ARG_A.
  - 2 CTRL: RW opcode in [OP_W-1:0]; bit 31 on write = START (self-clearing, reads 0).
  - 3 STATUS: RO; [BITS-1:0] captured result, bit 30 BUSY, bit 31 DONE; other bits 0.
- Transfer occurs in the access cycle (i_psel & i_penable & o_pready); writes update on that rising edge.
- FSM: IDLE, EXEC.
  - IDLE -> EXEC: accepted CTRL write with bit 31 = 1. Counter loaded with LATENCY, DONE cleared, o_start asserted the next cycle.
  - EXEC: counter decrements each cycle; on the cycle it equals 1, i_result is captured into RESULT, DONE is set, and the FSM returns to IDLE.
  - BUSY = (state == EXEC).
- Errors (o_pslverr = 1 in access cycle, register unchanged):
  - any write to ARG_A, ARG_B or CTRL while BUSY;
  - any write to STATUS.
- A CTRL write with bit 31 = 0 updates the opcode only and does not start an operation.
- Starting while DONE = 1 is legal; DONE is cleared on acceptance.
- Reading STATUS while BUSY inserts wait states: o_pready = 0 until the FSM is back in IDLE, then the read completes with the freshly captured result and DONE = 1.
- All other reads and writes complete with zero wait states.
- o_argA/o_argB/o_opcode are continuous register outputs. Software must not change them during EXEC, and the bus enforces this through the error rule above.

## Timing
- Reset (async assert): ARG_A, ARG_B, opcode and RESULT = 0; DONE = 0; state IDLE; o_start = 0; o_prdata = 0; o_pready = 1; o_pslverr = 0. Reset deassertion is synchronous to i_clk.
- o_prdata and o_pready are combinational from registers, state and APB inputs. o_prdata = 0 outside a read access cycle. o_pslverr is valid only in the access cycle and 0 otherwise.
- START accepted at edge T: BUSY = 1 from T; o_start = 1 for cycle T→T+1 only; RESULT captured at edge T+LATENCY; DONE = 1 and BUSY = 0 from T+LATENCY.
- Back-to-back: a START may be accepted in the first cycle after return to IDLE.
- Reset asserted during EXEC: immediate return to IDLE. A pending STATUS read is abandoned with o_pready = 1 and o_prdata = 0, and RESULT and DONE clear.

## Test plan
- Reset values: assert i_rst_n = 0 mid-cycle, then read all four registers -> 0x0, 0x0, 0x0, 0x0; o_start = 0, o_pready = 1.
- Basic op (BITS = 4, LATENCY = 2), with the downstream model returning 1 for A ≥ B: write ARG_A = 0x5, ARG_B = 0x3, CTRL = 0x8000_0002 -> o_start pulses once, o_opcode = 2, and a STATUS read 2 cycles later returns 0x8000_0001.
- Wait states: start with ARG_A = 0xE (−2), ARG_B = 0x1, then issue a STATUS read immediately -> o_pready low for 1 access cycle, then completes with 0x8000_0000.
- Busy errors: during EXEC, write ARG_A = 0x7 and write STATUS -> o_pslverr = 1 on both; ARG_A is unchanged on readback and BUSY is unaffected.
- Masking and no-start: write ARG_B = 0xFFFF_FFFF and read back -> 0x0000_000F; write CTRL = 0x0000_0005 -> no o_start, CTRL reads 0x5.
- Reset mid-op: assert reset 1 cycle after START acceptance -> state IDLE; STATUS reads 0x0 after release and o_start does not re-fire.
